// File: rtl/fnn_pkg.sv
// Shared types and constants for the fully connected layer sequencer.
//   seq_state_t    : sequencer FSM states
//   FNN_DATA_WIDTH : default sample / neuron-output width
//   clog2_min1     : $clog2 clamped to at least 1 bit, for counter widths
package fnn_pkg;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} seq_state_t;

  localparam int unsigned FNN_DATA_WIDTH = 16;

  // Counter widths must never collapse to zero bits for degenerate parameters.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fnn_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and its environment.
//   in_*         : upstream sample stream (valid/ready)
//   neuron_in*   : broadcast beat to every neuron
//   neuron_out*  : packed neuron results and per-neuron valid pulses
//   out_*        : serialized layer output stream (valid/ready, last)
// Modport master is the sequencer side, slave the environment side.
interface fnn_layer_sequencer_if
  import fnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FNN_DATA_WIDTH,
  parameter int unsigned NUM_NEURON = 30
);
  logic [DATA_WIDTH-1:0]            in_data;
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            neuron_in;
  logic                             neuron_in_valid;
  logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_out;
  logic [NUM_NEURON-1:0]            neuron_outvalid;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             out_valid;
  logic                             out_ready;
  logic                             out_last;

  modport master (
    input  in_data, in_valid, neuron_out, neuron_outvalid, out_ready,
    output in_ready, neuron_in, neuron_in_valid, out_data, out_valid, out_last
  );

  modport slave (
    output in_data, in_valid, neuron_out, neuron_outvalid, out_ready,
    input  in_ready, neuron_in, neuron_in_valid, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fnn_out_capture.sv
// Capture bank for neuron results plus the drain multiplexer.
//   capture_en_i   : accept outvalid pulses this cycle (WAIT only)
//   clear_i        : drop all capture flags (end of drain)
//   outvalid_i     : per-neuron result pulses
//   neuron_out_i   : packed neuron results, neuron i at [i*DATA_WIDTH +: DATA_WIDTH]
//   idx_i          : neuron slot selected for draining
//   all_captured_o : every slot captured, including pulses arriving this cycle
//   data_o         : selected slot, or 0 when that slot was never captured
module fnn_out_capture
  import fnn_pkg::*;
#(
  parameter int unsigned NUM_NEURON = 30,
  parameter int unsigned DATA_WIDTH = FNN_DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   capture_en_i,
  input  logic                                   clear_i,
  input  logic [NUM_NEURON-1:0]                  outvalid_i,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0]       neuron_out_i,
  input  logic [clog2_min1(NUM_NEURON)-1:0]      idx_i,
  output logic                                   all_captured_o,
  output logic [DATA_WIDTH-1:0]                  data_o
);
  localparam int unsigned IdxW = clog2_min1(NUM_NEURON);

  logic [DATA_WIDTH-1:0] bank_q [NUM_NEURON];
  logic [DATA_WIDTH-1:0] bank_d [NUM_NEURON];
  logic [NUM_NEURON-1:0] mask_q, mask_d, hit;

  // Only the first pulse per slot is kept; repeats are masked off.
  assign hit            = capture_en_i ? (outvalid_i & ~mask_q) : '0;
  assign all_captured_o = &(mask_q | hit);

  always_comb begin
    mask_d = clear_i ? '0 : (mask_q | hit);
    for (int i = 0; i < NUM_NEURON; i++) begin
      bank_d[i] = hit[i] ? neuron_out_i[i*DATA_WIDTH +: DATA_WIDTH] : bank_q[i];
    end
  end

  // Stale bank contents from an earlier run must never leak: gate by mask.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_NEURON; i++) begin
      if (idx_i == IdxW'(i) && mask_q[i]) data_o = bank_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      for (int i = 0; i < NUM_NEURON; i++) bank_q[i] <= '0;
    end else begin
      mask_q <= mask_d;
      for (int i = 0; i < NUM_NEURON; i++) bank_q[i] <= bank_d[i];
    end
  end
endmodule

// File: rtl/fnn_layer_sequencer.sv
// Sequences one fully connected layer through one inference: broadcasts
// NUM_INPUT samples to all neurons, collects every neuron result, then drains
// the results in neuron order on a valid/ready stream.
//   clk, rst_n    : clock and asynchronous active-low reset
//   bus           : handshake bundle (master side)
//   busy_o        : FSM not idle
//   layer_done_o  : pulse in the cycle the last output beat is accepted
//   timeout_err_o : sticky, set when WAIT gives up on missing neuron results
module fnn_layer_sequencer
  import fnn_pkg::*;
#(
  parameter int unsigned NUM_INPUT    = 784,
  parameter int unsigned NUM_NEURON   = 30,
  parameter int unsigned DATA_WIDTH   = FNN_DATA_WIDTH,
  parameter int unsigned WAIT_TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  fnn_layer_sequencer_if.master        bus,
  output logic                         busy_o,
  output logic                         layer_done_o,
  output logic                         timeout_err_o
);
  localparam int unsigned CntW = clog2_min1(NUM_INPUT + 1);
  localparam int unsigned IdxW = clog2_min1(NUM_NEURON);
  localparam int unsigned TmoW = clog2_min1(WAIT_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastSample = CntW'(NUM_INPUT - 1);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_NEURON - 1);
  localparam logic [TmoW-1:0] TmoLast    = (WAIT_TIMEOUT == 0) ? '0 : TmoW'(WAIT_TIMEOUT - 1);

  seq_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0] nin_q, nin_d;
  logic                  ninv_q, ninv_d;
  logic                  accept, beat_fire, last_beat, tmo_hit, drain_end, all_captured;
  logic [DATA_WIDTH-1:0] cap_data;

  assign accept    = bus.in_valid & in_ready_q;
  assign beat_fire = (state_q == DRAIN) & bus.out_ready;
  assign last_beat = (idx_q == LastIdx);
  assign drain_end = beat_fire & last_beat;
  // tmo_q counts completed WAIT cycles; the hit fires on the WAIT_TIMEOUT-th one.
  assign tmo_hit   = (WAIT_TIMEOUT != 0) && (tmo_q == TmoLast);

  fnn_out_capture #(
    .NUM_NEURON (NUM_NEURON),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_capture (
    .clk            (clk),
    .rst_n          (rst_n),
    .capture_en_i   (state_q == WAIT),
    .clear_i        (drain_end),
    .outvalid_i     (bus.neuron_outvalid),
    .neuron_out_i   (bus.neuron_out),
    .idx_i          (idx_q),
    .all_captured_o (all_captured),
    .data_o         (cap_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FEED;
      FEED:    if (accept && cnt_q == LastSample) state_d = WAIT;
      WAIT:    if (all_captured || tmo_hit) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, input register and registered in_ready
  always_comb begin
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    idx_d      = idx_q;
    err_d      = err_q;
    nin_d      = nin_q;
    ninv_d     = accept;
    in_ready_d = (state_d == FEED);
    if (accept) begin
      cnt_d = cnt_q + CntW'(1);
      nin_d = bus.in_data;
    end
    if (state_q == WAIT) begin
      tmo_d = tmo_q + TmoW'(1);
      if (tmo_hit && !all_captured) err_d = 1'b1;
    end
    if (beat_fire) idx_d = idx_q + IdxW'(1);
    if (drain_end) begin
      cnt_d = '0;
      tmo_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      tmo_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      nin_q      <= '0;
      ninv_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      nin_q      <= nin_d;
      ninv_q     <= ninv_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Outputs
  always_comb begin
    busy_o          = (state_q != IDLE);
    bus.out_valid   = (state_q == DRAIN);
    bus.out_data    = (state_q == DRAIN) ? cap_data : '0;
    bus.out_last    = (state_q == DRAIN) & last_beat;
    layer_done_o    = drain_end;
    timeout_err_o   = err_q;
    bus.in_ready    = in_ready_q;
    bus.neuron_in   = nin_q;
    bus.neuron_in_valid = ninv_q;
  end
endmodule

// File: tb/tb_fnn_layer_sequencer.sv
// Self-checking bench for fnn_layer_sequencer (NUM_INPUT=4, NUM_NEURON=3,
// WAIT_TIMEOUT=20). Expected drain values come from a first-pulse-wins model
// over a schedule of pulses indexed by WAIT cycle.
module tb_fnn_layer_sequencer;
  import fnn_pkg::*;

  localparam int unsigned NI = 4;
  localparam int unsigned NN = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned WT = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fnn_layer_sequencer_if #(.DATA_WIDTH(DW), .NUM_NEURON(NN)) bus ();
  logic busy, layer_done, timeout_err;

  fnn_layer_sequencer #(
    .NUM_INPUT    (NI),
    .NUM_NEURON   (NN),
    .DATA_WIDTH   (DW),
    .WAIT_TIMEOUT (WT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy_o        (busy),
    .layer_done_o  (layer_done),
    .timeout_err_o (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {int t; int n; logic [DW-1:0] v;} pulse_t;
  pulse_t          pq[$];
  logic [DW-1:0]   nq[$];
  logic [DW-1:0]   smp[NI];
  logic [DW-1:0]   ev[NN];
  bit              err_exp = 1'b0;

  always @(negedge clk) if (rst_n && bus.neuron_in_valid) nq.push_back(bus.neuron_in);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_pulse(input int t, input int n, input logic [DW-1:0] v);
    pulse_t p;
    p.t = t; p.n = n; p.v = v;
    pq.push_back(p);
  endtask

  task automatic feed(input bit gappy, input bit stray, input int want);
    int n = 0;
    int g = 0;
    while (n < want && g < 200) begin
      bus.in_valid = gappy ? (g % 2 == 0) : 1'b1;
      bus.in_data  = smp[n];
      if (stray) begin
        bus.neuron_outvalid = '1;
        bus.neuron_out      = {NN{16'hBEEF}};
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) n++;
      @(posedge clk); #1;
      g++;
    end
    bus.in_valid        = 1'b0;
    bus.neuron_outvalid = '0;
    bus.neuron_out      = '0;
    chk("feed_count", n, want);
  endtask

  // Model: per neuron the earliest WAIT-cycle pulse wins; DRAIN starts the cycle
  // after the last slot fills, or after WT WAIT cycles with empty slots as 0.
  task automatic wait_phase();
    int  f[NN];
    logic [DW-1:0] fv[NN];
    int  maxf = 0, last_t = 0, entry, len;
    bit  complete = 1'b1, tmo;
    for (int i = 0; i < NN; i++) begin f[i] = -1; fv[i] = '0; end
    foreach (pq[k]) begin
      if (f[pq[k].n] < 0 || pq[k].t < f[pq[k].n]) begin
        f[pq[k].n] = pq[k].t; fv[pq[k].n] = pq[k].v;
      end
      if (pq[k].t > last_t) last_t = pq[k].t;
    end
    for (int i = 0; i < NN; i++) begin
      if (f[i] < 0) complete = 1'b0;
      else if (f[i] > maxf) maxf = f[i];
    end
    if (maxf > WT - 1) complete = 1'b0;
    tmo   = !complete;
    entry = complete ? maxf + 1 : WT;
    for (int i = 0; i < NN; i++) ev[i] = (f[i] >= 0 && f[i] < entry) ? fv[i] : '0;
    len = ((entry > last_t) ? entry : last_t) + 2;
    for (int c = 0; c < len; c++) begin
      foreach (pq[k]) if (pq[k].t == c) begin
        bus.neuron_outvalid[pq[k].n]          = 1'b1;
        bus.neuron_out[pq[k].n*DW +: DW]      = pq[k].v;
      end
      @(negedge clk);
      chk("wait_out_valid", bus.out_valid, c >= entry);
      chk("wait_in_ready", bus.in_ready, 0);
      chk("wait_busy", busy, 1);
      chk("wait_err", timeout_err, err_exp || (tmo && c >= entry));
      if (c >= entry) begin
        chk("hold_data", bus.out_data, ev[0]);
        chk("hold_last", bus.out_last, 0);
      end
      @(posedge clk); #1;
      bus.neuron_outvalid = '0;
      bus.neuron_out      = '0;
    end
    err_exp = err_exp | tmo;
  endtask

  task automatic drain(input int mode);
    int got = 0;
    int g = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev = '0;
    while (got < NN && g < 200) begin
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 1) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) chk("stall_stable", bus.out_data, prev);
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_data", bus.out_data, ev[got]);
        chk("beat_last", bus.out_last, got == NN - 1);
        chk("layer_done", layer_done, got == NN - 1);
        got++;
      end else begin
        chk("no_done", layer_done, 0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = bus.out_data;
      @(posedge clk); #1;
      g++;
    end
    bus.out_ready = 1'b0;
    chk("drain_beats", got, NN);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", bus.out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic run(input bit gappy, input bit stray, input int mode);
    nq.delete();
    feed(gappy, stray, NI);
    wait_phase();
    chk("neuron_beats", nq.size(), NI);
    for (int i = 0; i < NI; i++) if (i < nq.size()) chk("neuron_in", nq[i], smp[i]);
    drain(mode);
  endtask

  task automatic rand_samples();
    for (int i = 0; i < NI; i++) smp[i] = DW'($urandom);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_nin"}, bus.neuron_in, 0);
    chk({tag, "_nin_valid"}, bus.neuron_in_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, layer_done, 0);
    chk({tag, "_err"}, timeout_err, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.neuron_outvalid = '0;
    bus.neuron_out = '0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic
    for (int i = 0; i < NI; i++) smp[i] = DW'(i + 1);
    pq.delete();
    add_pulse(3, 0, 16'h0010); add_pulse(4, 1, 16'h0020); add_pulse(5, 2, 16'h0030);
    run(1'b0, 1'b0, 0);

    // 2: input gaps and output backpressure
    rand_samples(); pq.delete();
    for (int i = 0; i < NN; i++) add_pulse($urandom_range(0, 5), i, DW'($urandom));
    run(1'b1, 1'b0, 1);

    // 3a: all at once, then a repeat after completion
    rand_samples(); pq.delete();
    for (int i = 0; i < NN; i++) add_pulse(1, i, DW'($urandom));
    add_pulse(2, 1, 16'hFFFF);
    run(1'b0, 1'b0, 0);

    // 3b: repeat on an already captured slot while still waiting
    rand_samples(); pq.delete();
    add_pulse(0, 1, DW'($urandom)); add_pulse(1, 1, 16'hFFFF);
    add_pulse(2, 0, DW'($urandom)); add_pulse(2, 1, 16'hFFFF); add_pulse(2, 2, DW'($urandom));
    run(1'b0, 1'b0, 1);

    // 4: timeout with only neuron 0 answering
    rand_samples(); pq.delete();
    add_pulse(2, 0, 16'h0011);
    run(1'b0, 1'b0, 0);

    // 5: reset in the middle of FEED
    rand_samples(); nq.delete();
    feed(1'b0, 1'b0, 2);
    rst_n = 1'b0;
    #1 check_zero_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    err_exp = 1'b0;
    for (int i = 0; i < NI; i++) smp[i] = DW'(i + 1);
    pq.delete();
    add_pulse(3, 0, 16'h0010); add_pulse(4, 1, 16'h0020); add_pulse(5, 2, 16'h0030);
    run(1'b0, 1'b0, 0);

    // 6: stray outvalid during FEED
    rand_samples(); pq.delete();
    for (int i = 0; i < NN; i++) add_pulse($urandom_range(1, 6), i, DW'($urandom));
    run(1'b0, 1'b1, 0);

    // Randomized runs, some of which time out
    for (int r = 0; r < 5; r++) begin
      rand_samples(); pq.delete();
      for (int i = 0; i < NN; i++) add_pulse($urandom_range(0, 24), i, DW'($urandom));
      add_pulse($urandom_range(0, 24), $urandom_range(0, NN - 1), DW'($urandom));
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
